// File: rtl/disp_owner_arbiter.sv
// Round-robin owner arbiter for the shared four-digit seven-segment display.
// Grants one of three requesters, holds each grant for a minimum dwell, preempts
// a long-running owner when others wait, and registers the owner's digits/dps
// for the downstream display multiplexer.
module disp_owner_arbiter #(
  parameter int unsigned DWELL    = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] hex_a,
  input  logic [15:0] hex_b,
  input  logic [15:0] hex_c,
  input  logic [3:0]  dp_a,
  input  logic [3:0]  dp_b,
  input  logic [3:0]  dp_c,
  output logic [2:0]  gnt,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic [3:0]  dp_out,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(MAX_HOLD);
  localparam logic [CntW-1:0] CntMax    = CntW'(MAX_HOLD - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0]  owner_oh;
  logic [2:0]  others_req;
  logic        other_pending;
  logic        dwell_done;
  logic        release_now;
  logic [1:0]  pick_idle;
  logic [1:0]  pick_next;
  logic [15:0] sel_hex;
  logic [3:0]  sel_dp;

  // First requester found searching upward from (from+1) mod 3, with wrap.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] from);
    logic [1:0] cand;
    rr_pick = from;
    // Descending offsets so the smallest offset (closest after 'from') wins.
    for (int k = 2; k >= 0; k--) begin
      cand = 2'((int'(from) + 1 + k) % 3);
      if (r[cand]) rr_pick = cand;
    end
  endfunction

  assign owner_oh      = 3'b001 << owner_q;
  assign others_req    = req & ~owner_oh;
  assign other_pending = |others_req;
  assign dwell_done    = (cnt_q >= DwellLast);
  assign release_now   = dwell_done && (!req[owner_q] || (other_pending && cnt_q == CntMax));
  assign pick_idle     = rr_pick(req, last_q);
  // Searching from the owner puts it last in order; masking it keeps it out entirely.
  assign pick_next     = rr_pick(others_req, owner_q);

  // Next-state, owner, round-robin pointer and dwell/hold counter.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          owner_d = pick_idle;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (release_now) begin
          last_d = owner_q;
          cnt_d  = '0;
          if (other_pending) begin
            owner_d = pick_next;
          end else begin
            state_d = StIdle;
          end
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Display data of whichever requester will own the display after this edge.
  always_comb begin
    unique case (owner_d)
      2'd0:    begin sel_hex = hex_a; sel_dp = dp_a; end
      2'd1:    begin sel_hex = hex_b; sel_dp = dp_b; end
      default: begin sel_hex = hex_c; sel_dp = dp_c; end
    endcase
  end

  // State, grant and registered display outputs; data tracks live while granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      gnt     <= 3'b000;
      hex3    <= 4'h0;
      hex2    <= 4'h0;
      hex1    <= 4'h0;
      hex0    <= 4'h0;
      dp_out  <= 4'b1111;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (state_d == StGrant) begin
        gnt    <= 3'b001 << owner_d;
        hex3   <= sel_hex[15:12];
        hex2   <= sel_hex[11:8];
        hex1   <= sel_hex[7:4];
        hex0   <= sel_hex[3:0];
        dp_out <= sel_dp;
      end else begin
        gnt <= 3'b000;
      end
    end
  end

  assign busy = (gnt != 3'b000);

endmodule
